seq_pattern_detector: RTL and testbench
=======================================

Name: seq_pattern_detector

Overview:
Parametrised serial bit-pattern detector, successor to the fixed 110101 detector FSM. It matches a runtime-programmable pattern of 1..MAX_LEN bits against a serial stream qualified by a valid strobe. Overlapping or non-overlapping matching is selectable, and a saturating match counter is provided. It sits on serial control/monitor links as a programmable trigger source.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 16, match counter width
LEN_W, $clog2(MAX_LEN+1), width of length field (derived, not overridden)
DEFAULT_PATTERN, 8'b0011_0101, reset pattern value; the LSB-aligned 6'b110101
DEFAULT_LEN, 6, reset pattern length
DEFAULT_OVERLAP, 1, reset overlap mode

Ports:
clk  in  1  clock; all state updates on rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  in is sampled only when high
in  in  1  serial data bit
cfg_load  in  1  one-cycle strobe; captures cfg_* fields
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping matches allowed
cnt_clr  in  1  synchronous clear of match_cnt
out  out  1  registered one-cycle match pulse
match_cnt  out  CNT_W  saturating count of matches

Behaviour:
- Reset (async, rstn low): hist=0, fill=0, out=0, match_cnt=0. pattern=DEFAULT_PATTERN, len=DEFAULT_LEN, overlap=DEFAULT_OVERLAP.
- History: on an in_valid cycle, hist <= {hist[MAX_LEN-2:0], in} (newest bit at LSB). fill <= min(fill+1, MAX_LEN).
- When in_valid is low, hist and fill hold and no match can occur.
- Match condition, evaluated on the post-shift values in an in_valid cycle: next_hist[len-1:0] == pattern[len-1:0] and next_fill >= len.
- Latency: out=1 in the cycle after the clock edge that samples the final pattern bit. out is high for exactly one cycle per match and is 0 in every other cycle.
- Overlap=1: fill continues after a match, so the suffix of a match may start the next one.
- Overlap=0: on a match, fill <= 0, so following bits begin a fresh window.
- cfg_load: captures pattern, len and overlap, and clears hist and fill.
  - An in_valid bit in the same cycle is discarded.
  - out is 0 in the next cycle.
  - match_cnt is not affected.
- Length clamp at load: cfg_len=0 is stored as 1; cfg_len>MAX_LEN is stored as MAX_LEN.
- match_cnt increments by 1 per match and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr alone sets it to 0.
  - cnt_clr and a match in the same cycle set it to 1.
- Reset mid-stream: all partial progress is lost immediately (async). Detection restarts from an empty window after rstn deasserts.
- Pattern bits above len-1 are don't-care.

Test Plan:
1. Reset defaults; stream 1,1,0,1,0,1 with in_valid=1 -> out=1 for one cycle, on the cycle after bit 6; match_cnt=1.
2. Load pattern=3'b101, len=3, overlap=1; stream 1,0,1,0,1 -> out pulses after bits 3 and 5, match_cnt=2. Reload with overlap=0 and repeat the stream -> pulse after bit 3 only, match_cnt=3.
3. Defaults, with in_valid low for 2 cycles between each bit of 110101 -> a single out pulse, on the cycle after the last valid bit; no pulses during idle cycles.
4. Send 1,1,0,1, then load pattern=2'b01, len=2; send 1 -> no match. Send 0,1 -> match after the final 1. Load cfg_len=0 with pattern bit0=1; send 1 -> match (len stored as 1).
5. CNT_W=4, pattern=1'b1, len=1; 17 valid ones -> match_cnt saturates at 15. Assert cnt_clr together with a matching bit -> match_cnt=1.
6. Send 1,1,0,1,0, then pulse rstn low between clock edges -> out=0 and match_cnt=0 immediately. After release send 1 -> no match. A full 110101 afterwards -> match.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - programmable serial bit-pattern detector with saturating match counter
module seq_pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 16,
  localparam int LEN_W = $clog2(MAX_LEN + 1),
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0011_0101,
  parameter int DEFAULT_LEN = 6,
  parameter logic DEFAULT_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_out;
  logic [CNT_W-1:0]   r_cnt;

  logic [MAX_LEN-1:0] w_next_hist;
  logic [LEN_W-1:0]   w_next_fill;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_load_len;
  logic               w_match;

  assign w_next_hist = {r_hist[MAX_LEN-2:0], in};
  assign w_next_fill = (r_fill >= MAX_LEN_L) ? MAX_LEN_L : r_fill + LEN_W'(1);

  // Only the low len bits of history/pattern take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  always_comb begin
    w_load_len = cfg_len;
    if (cfg_len == '0) begin
      w_load_len = LEN_W'(1);
    end else if (cfg_len > MAX_LEN_L) begin
      w_load_len = MAX_LEN_L;
    end
  end

  // A load cycle discards the incoming bit, so it can never produce a match.
  assign w_match = in_valid && !cfg_load &&
                   (((w_next_hist ^ r_pattern) & w_mask) == '0) &&
                   (w_next_fill >= r_len);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= DEFAULT_PATTERN;
      r_len     <= LEN_W'(DEFAULT_LEN);
      r_overlap <= DEFAULT_OVERLAP;
      r_out     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_out <= w_match;
      if (cfg_load) begin
        r_pattern <= cfg_pattern;
        r_len     <= w_load_len;
        r_overlap <= cfg_overlap;
        r_hist    <= '0;
        r_fill    <= '0;
      end else if (in_valid) begin
        r_hist <= w_next_hist;
        r_fill <= (w_match && !r_overlap) ? '0 : w_next_fill;
      end

      if (cnt_clr) begin
        r_cnt <= w_match ? CNT_W'(1) : '0;
      end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out       = r_out;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - directed self-checking bench for seq_pattern_detector
module tb_seq_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int CNT_W = 4;
  localparam int LEN_W = 4;

  logic               clk = 1'b0;
  logic               rstn;
  logic               in_valid;
  logic               in_bit;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;

  int checks = 0;
  int errors = 0;

  seq_pattern_detector #(
    .MAX_LEN(MAX_LEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .in_valid(in_valid),
    .in(in_bit),
    .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr),
    .out(out),
    .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic send(input logic b, input logic exp_out, input string tag);
    step(1'b1, b);
    chk(tag, {31'd0, out}, {31'd0, exp_out});
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0);
    chk(tag, {31'd0, out}, 32'd0);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                      input logic v, input logic b);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    step(v, b);
    chk("load_out", {31'd0, out}, 32'd0);
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    step(1'b0, 1'b0);
    chk("cnt_clr", {28'd0, match_cnt}, 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #3;
    chk("rst_out", {31'd0, out}, 32'd0);
    chk("rst_cnt", {28'd0, match_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {31'd0, out}, 32'd0);
    chk("reset_cnt", {28'd0, match_cnt}, 32'd0);
    rstn = 1'b1;

    // 1: default 110101
    send(1, 0, "t1_b1"); send(1, 0, "t1_b2"); send(0, 0, "t1_b3");
    send(1, 0, "t1_b4"); send(0, 0, "t1_b5"); send(1, 1, "t1_b6");
    idle("t1_pulse_end");
    chk("t1_cnt", {28'd0, match_cnt}, 32'd1);
    clear_cnt();

    // 2: 101 overlapping, then non-overlapping
    load(8'b101, 4'd3, 1'b1, 1'b1, 1'b1);
    send(1, 0, "t2o_b1"); send(0, 0, "t2o_b2"); send(1, 1, "t2o_b3");
    send(0, 0, "t2o_b4"); send(1, 1, "t2o_b5");
    chk("t2o_cnt", {28'd0, match_cnt}, 32'd2);
    load(8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
    send(1, 0, "t2n_b1"); send(0, 0, "t2n_b2"); send(1, 1, "t2n_b3");
    send(0, 0, "t2n_b4"); send(1, 0, "t2n_b5");
    chk("t2n_cnt", {28'd0, match_cnt}, 32'd3);

    // 3: defaults with gaps of invalid cycles
    do_reset();
    send(1, 0, "t3_b1"); idle("t3_i1a"); idle("t3_i1b");
    send(1, 0, "t3_b2"); idle("t3_i2a"); idle("t3_i2b");
    send(0, 0, "t3_b3"); idle("t3_i3a"); idle("t3_i3b");
    send(1, 0, "t3_b4"); idle("t3_i4a"); idle("t3_i4b");
    send(0, 0, "t3_b5"); idle("t3_i5a"); idle("t3_i5b");
    send(1, 1, "t3_b6"); idle("t3_i6a"); idle("t3_i6b");
    chk("t3_cnt", {28'd0, match_cnt}, 32'd1);

    // 4: load clears window and discards same-cycle bit; length clamps
    send(1, 0, "t4_p1"); send(1, 0, "t4_p2"); send(0, 0, "t4_p3"); send(1, 0, "t4_p4");
    load(8'b01, 4'd2, 1'b1, 1'b1, 1'b0);
    send(1, 0, "t4_after_load");
    send(0, 0, "t4_b0");
    send(1, 1, "t4_b1");
    chk("t4_cnt_keep", {28'd0, match_cnt}, 32'd2);
    load(8'b0000_0001, 4'd0, 1'b1, 1'b0, 1'b0);
    send(1, 1, "t4_len0_1");
    send(0, 0, "t4_len0_0");
    load(8'hFF, 4'd15, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) send(1, 0, "t4_long_fill");
    send(1, 1, "t4_long_b8");
    send(1, 1, "t4_long_b9");

    // 5: counter saturation and clear-with-match
    load(8'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    clear_cnt();
    for (int i = 1; i <= 17; i++) begin
      send(1, 1, "t5_match");
      chk("t5_cnt", {28'd0, match_cnt}, (i > 15) ? 32'd15 : 32'(i));
    end
    cnt_clr = 1'b1;
    send(1, 1, "t5_clr_match");
    chk("t5_clr_match_cnt", {28'd0, match_cnt}, 32'd1);

    // 6: async reset mid-stream
    load(8'b0011_0101, 4'd6, 1'b1, 1'b0, 1'b0);
    send(1, 0, "t6_b1"); send(1, 0, "t6_b2"); send(0, 0, "t6_b3");
    send(1, 0, "t6_b4"); send(0, 0, "t6_b5");
    chk("t6_cnt_pre", {28'd0, match_cnt}, 32'd1);
    #2;
    do_reset();
    send(1, 0, "t6_post_rst");
    send(1, 0, "t6_c1"); send(0, 0, "t6_c2"); send(1, 0, "t6_c3");
    send(0, 0, "t6_c4"); send(1, 1, "t6_c5");
    idle("t6_end");
    chk("t6_cnt", {28'd0, match_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
